// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction decode queue.
// The entry layout is fixed here; the queue's ADDR_W/SEQ_W defaults track these values.
package riscv_pkg;

    localparam int IDQ_ADDR_W = 32;
    localparam int IDQ_SEQ_W  = 64;
    localparam int IDQ_DATA_W = 32;

    // Keeps the low half of a word; a compressed instruction lives in [15:0].
    localparam logic [31:0] C_HI_MASK = 32'h0000_FFFF;

    typedef struct packed {
        logic [IDQ_SEQ_W-1:0]  seq;
        logic [IDQ_ADDR_W-1:0] addr;
        logic [IDQ_DATA_W-1:0] data;
        logic                  defined;
        logic                  compressed;
    } idq_entry_t;

endpackage

// File: rtl/riscv_decode.sv
// Lightweight RV32I/RVC classifier.
// Flags 16-bit encodings and recognises the base major opcodes.
module riscv_decode (
    input  logic [31:0] instr,
    output logic        defined,
    output logic        compressed
);

    // Only the low half and the major opcode fields take part in classification.
    logic unused_hi;
    assign unused_hi = ^instr[31:16];

    always_comb begin
        compressed = (instr[1:0] != 2'b11);
        defined    = 1'b0;
        if (compressed) begin
            // The all-zero halfword is the architecturally illegal instruction.
            defined = (instr[15:0] != 16'h0000);
        end else begin
            case (instr[6:0])
                7'b0110111, 7'b0010111, 7'b1101111,
                7'b1100011, 7'b0000011, 7'b0100011,
                7'b0010011, 7'b0110011, 7'b0001111,
                7'b1110011: defined = 1'b1;
                7'b1100111: defined = (instr[14:12] == 3'b000);
                default:    defined = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/riscv_idq.sv
// Decode queue between fetch and execute: decodes, sequence-tags and buffers
// up to DEPTH instructions behind valid/ready handshakes, with a pipeline flush.
module riscv_idq
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = IDQ_ADDR_W,
    parameter int SEQ_W  = IDQ_SEQ_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   ifu_vld,
    output logic                   ifu_rdy,
    input  logic [ADDR_W-1:0]      ifu_addr,
    input  logic [31:0]            ifu_data,
    output logic                   idu_vld,
    input  logic                   idu_rdy,
    output logic [SEQ_W-1:0]       idu_seq,
    output logic [ADDR_W-1:0]      idu_addr,
    output logic [31:0]            idu_data,
    output logic                   idu_defined,
    output logic                   idu_compressed,
    output logic [$clog2(DEPTH):0] idu_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on the same-side valid, and an offered
    // valid with its payload is held by the producer until it is accepted.

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEQ_W-1:0] seq_ctr_q, seq_ctr_d;
    idq_entry_t       mem_q [DEPTH];
    idq_entry_t       entry_d;
    idq_entry_t       head;
    logic             dec_defined;
    logic             dec_compressed;
    logic             push;
    logic             pop;

    riscv_decode u_decode (
        .instr      (ifu_data),
        .defined    (dec_defined),
        .compressed (dec_compressed)
    );

    assign ifu_rdy = (cnt_q != CNT_W'(DEPTH)) & ~flush;
    assign idu_vld = (cnt_q != '0);
    assign push    = ifu_vld & ifu_rdy;
    assign pop     = idu_vld & idu_rdy;

    always_comb begin
        wr_ptr_d           = wr_ptr_q;
        rd_ptr_d           = rd_ptr_q;
        cnt_d              = cnt_q;
        seq_ctr_d          = seq_ctr_q;
        entry_d            = '0;
        entry_d.seq        = seq_ctr_q;
        entry_d.addr       = ifu_addr;
        entry_d.data       = dec_compressed ? (ifu_data & C_HI_MASK) : ifu_data;
        entry_d.defined    = dec_defined;
        entry_d.compressed = dec_compressed;
        // The sequence counter survives a flush so tags stay unique afterwards.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                seq_ctr_d = seq_ctr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            seq_ctr_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            seq_ctr_q <= seq_ctr_d;
        end
    end

    // Storage carries no reset; an empty queue masks it at the outputs.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign head           = idu_vld ? mem_q[rd_ptr_q] : '0;
    assign idu_seq        = head.seq;
    assign idu_addr       = head.addr;
    assign idu_data       = head.data;
    assign idu_defined    = head.defined;
    assign idu_compressed = head.compressed;
    assign idu_count      = cnt_q;

endmodule

// File: tb/tb_riscv_idq.sv
// Directed bench for riscv_idq: decode tagging, full/backpressure, wrap,
// flush, asynchronous reset and sequence-counter rollover.
module tb_riscv_idq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        ifu_vld = 1'b0;
    logic        ifu_rdy;
    logic [31:0] ifu_addr = '0;
    logic [31:0] ifu_data = '0;
    logic        idu_vld;
    logic        idu_rdy = 1'b0;
    logic [63:0] idu_seq;
    logic [31:0] idu_addr;
    logic [31:0] idu_data;
    logic        idu_defined;
    logic        idu_compressed;
    logic [2:0]  idu_count;

    int n_assert = 0;
    int n_fail   = 0;

    riscv_idq #(.DEPTH(4), .ADDR_W(32), .SEQ_W(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .ifu_vld        (ifu_vld),
        .ifu_rdy        (ifu_rdy),
        .ifu_addr       (ifu_addr),
        .ifu_data       (ifu_data),
        .idu_vld        (idu_vld),
        .idu_rdy        (idu_rdy),
        .idu_seq        (idu_seq),
        .idu_addr       (idu_addr),
        .idu_data       (idu_data),
        .idu_defined    (idu_defined),
        .idu_compressed (idu_compressed),
        .idu_count      (idu_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] addr, input logic [31:0] data);
        ifu_vld  = 1'b1;
        ifu_addr = addr;
        ifu_data = data;
    endtask

    task automatic do_reset();
        ifu_vld = 1'b0;
        idu_rdy = 1'b0;
        flush   = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_vld",   idu_vld,   0);
        chk("rst_rdy",   ifu_rdy,   1);
        chk("rst_count", idu_count, 0);
        chk("rst_seq",   idu_seq,   0);
        chk("rst_data",  idu_data,  0);
        tick();
        reset = 1'b0;

        // Three words streamed with idu_rdy high, latency 1
        idu_rdy = 1'b1;
        send(32'h100, 32'h0050_0093);
        tick();
        chk("s0_vld",  idu_vld,        1);
        chk("s0_seq",  idu_seq,        0);
        chk("s0_addr", idu_addr,       32'h100);
        chk("s0_data", idu_data,       32'h0050_0093);
        chk("s0_def",  idu_defined,    1);
        chk("s0_cmp",  idu_compressed, 0);
        chk("s0_cnt",  idu_count,      1);
        send(32'h104, 32'hDEAD_4501);
        tick();
        chk("s1_seq",  idu_seq,        1);
        chk("s1_data", idu_data,       32'h0000_4501);
        chk("s1_def",  idu_defined,    1);
        chk("s1_cmp",  idu_compressed, 1);
        chk("s1_cnt",  idu_count,      1);
        send(32'h106, 32'hFFFF_FFFF);
        tick();
        chk("s2_seq",  idu_seq,        2);
        chk("s2_addr", idu_addr,       32'h106);
        chk("s2_def",  idu_defined,    0);
        chk("s2_cmp",  idu_compressed, 0);
        ifu_vld = 1'b0;
        tick();
        chk("s3_vld",  idu_vld,   0);
        chk("s3_cnt",  idu_count, 0);
        chk("s3_data", idu_data,  0);
        chk("s3_seq",  idu_seq,   0);

        // Fill to DEPTH with consumer stalled, hold a fifth word
        do_reset();
        send(32'h200, 32'h0000_0013); tick(); chk("f_cnt1", idu_count, 1);
        send(32'h204, 32'h0000_0093); tick(); chk("f_cnt2", idu_count, 2);
        send(32'h208, 32'h0000_0113); tick(); chk("f_cnt3", idu_count, 3);
        send(32'h20C, 32'h0000_0193); tick(); chk("f_cnt4", idu_count, 4);
        chk("f_rdy_full", ifu_rdy, 0);
        send(32'h210, 32'h0000_0213);
        tick();
        tick();
        chk("f_hold_cnt", idu_count, 4);
        chk("f_hold_rdy", ifu_rdy,   0);
        chk("f_hold_seq", idu_seq,   0);
        chk("f_hold_adr", idu_addr,  32'h200);
        idu_rdy = 1'b1;
        tick();
        chk("f_d0_seq", idu_seq,   1);
        chk("f_d0_cnt", idu_count, 3);
        chk("f_d0_rdy", ifu_rdy,   1);
        tick();
        chk("f_d1_seq", idu_seq,   2);
        chk("f_d1_cnt", idu_count, 3);
        ifu_vld = 1'b0;
        tick();
        chk("f_d2_seq", idu_seq,   3);
        chk("f_d2_cnt", idu_count, 2);
        tick();
        chk("f_d3_seq",  idu_seq,     4);
        chk("f_d3_addr", idu_addr,    32'h210);
        chk("f_d3_data", idu_data,    32'h0000_0213);
        chk("f_d3_def",  idu_defined, 1);
        chk("f_d3_cnt",  idu_count,   1);
        tick();
        chk("f_d4_cnt", idu_count, 0);
        chk("f_d4_vld", idu_vld,   0);

        // Concurrent push/pop at occupancy 2, pointers wrap repeatedly
        idu_rdy = 1'b0;
        send(32'h305, 32'h0000_0013); tick();
        send(32'h306, 32'h0000_0013); tick();
        chk("w_cnt0", idu_count, 2);
        chk("w_seq0", idu_seq,   5);
        idu_rdy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            send(32'h306 + k, 32'h0000_0013);
            tick();
            chk("w_seq",  idu_seq,   64'(5 + k));
            chk("w_addr", idu_addr,  32'(32'h305 + k));
            chk("w_cnt",  idu_count, 2);
        end
        ifu_vld = 1'b0;
        tick();
        chk("w_tail_seq", idu_seq,   16);
        chk("w_tail_cnt", idu_count, 1);
        tick();
        chk("w_empty", idu_count, 0);

        // Flush with three queued entries and a word on offer
        do_reset();
        send(32'h400, 32'h0000_0013); tick();
        send(32'h404, 32'h0000_0013); tick();
        send(32'h408, 32'h0000_0013); tick();
        chk("fl_cnt3", idu_count, 3);
        send(32'h40C, 32'h0000_0013);
        flush   = 1'b1;
        idu_rdy = 1'b1;
        #1;
        chk("fl_rdy_low", ifu_rdy, 0);
        tick();
        chk("fl_cnt0",  idu_count, 0);
        chk("fl_vld0",  idu_vld,   0);
        chk("fl_data0", idu_data,  0);
        flush   = 1'b0;
        idu_rdy = 1'b0;
        #1;
        chk("fl_rdy_back", ifu_rdy, 1);
        tick();
        chk("fl_next_seq",  idu_seq,   3);
        chk("fl_next_addr", idu_addr,  32'h40C);
        chk("fl_next_cnt",  idu_count, 1);

        // Asynchronous reset between edges, mid-burst
        send(32'h410, 32'h0000_0013);
        tick();
        chk("ar_cnt2", idu_count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_vld",  idu_vld,   0);
        chk("ar_seq",  idu_seq,   0);
        chk("ar_addr", idu_addr,  0);
        chk("ar_data", idu_data,  0);
        chk("ar_cnt",  idu_count, 0);
        chk("ar_rdy",  ifu_rdy,   1);
        ifu_vld = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        send(32'h500, 32'h0000_4501);
        tick();
        chk("ar_first_seq", idu_seq,        0);
        chk("ar_first_cmp", idu_compressed, 1);

        // Sequence counter rollover
        ifu_vld = 1'b0;
        idu_rdy = 1'b1;
        tick();
        chk("sw_empty", idu_count, 0);
        idu_rdy = 1'b0;
        force dut.seq_ctr_q = {64{1'b1}};
        #1;
        release dut.seq_ctr_q;
        send(32'h600, 32'h0000_0013); tick();
        chk("sw_max", idu_seq, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h604, 32'h0000_0013); tick();
        chk("sw_cnt2", idu_count, 2);
        ifu_vld = 1'b0;
        idu_rdy = 1'b1;
        tick();
        chk("sw_zero",      idu_seq,  0);
        chk("sw_zero_addr", idu_addr, 32'h604);
        tick();
        chk("sw_drained", idu_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
